llr_frame_buffer: RTL
=====================

Name: llr_frame_buffer

Overview:
- Input-side frame buffer for the LDPC decoder.
- Accepts channel LLR words from the upstream stream interface into two ping-pong frame banks, and reports the number of resident complete frames to the decoder controller on flag_buffer_in.
- On each flag_org_update pulse from the controller, copies one resident frame word-by-word into ram_llr, then pulses flag_org_write_end.
- It is the producer end of the controller's flag_buffer_in / flag_org_update / flag_org_write_end handshake.

Parameters:
- DATA_W, 64, width of one LLR word (packed LLRs) on the input stream and the ram_llr write port
- FRAME_WORDS, 533, words per frame; the bench overrides this to 4
- ADDR_W, 10, ram_llr address width; must satisfy 2^ADDR_W >= FRAME_WORDS

Ports:
- sys_clk  in  1  clock
- sys_rst  in  1  synchronous active-high reset
- in_valid  in  1  input word valid
- in_data  in  DATA_W  input LLR word
- in_ready  out  1  buffer can accept in_data this cycle
- flag_org_update  in  1  one-cycle request from controller: load next frame into ram_llr
- flag_buffer_in  out  2  number of complete frames resident (0..2)
- flag_org_write_end  out  1  one-cycle pulse: frame fully written to ram_llr
- llr_wr_en  out  1  ram_llr write enable
- llr_wr_addr  out  ADDR_W  ram_llr write address
- llr_wr_data  out  DATA_W  ram_llr write data
- err_update  out  1  sticky: flag_org_update received while transferring or with no frame resident

Behaviour:
- Reset is synchronous, sys_rst=1 at a clock edge; it aborts any transfer immediately with no write_end pulse. Every output resets to 0: in_ready, flag_buffer_in, flag_org_write_end, llr_wr_en, llr_wr_addr, llr_wr_data, err_update. Internal wr_bank, rd_bank, word counters and the state also reset to 0. Bank contents are don't-care.
- in_ready is registered. It equals (frame count < 2) and is recomputed every cycle from the next-state count; in_ready=1 in the first cycle after reset deasserts.
- Fill side:
  - A word is accepted when in_valid & in_ready. It is stored at bank wr_bank, index wr_cnt, and wr_cnt increments.
  - On accepting word FRAME_WORDS-1: wr_cnt wraps to 0, wr_bank toggles, and the frame count increments.
  - Partial frames are not counted.
- State machine, IDLE / XFER:
  - IDLE: if flag_org_update=1 and count != 0, go to XFER with rd_cnt=0. If flag_org_update=1 and count=0, stay in IDLE and set err_update.
  - XFER: a read of bank rd_bank at rd_cnt issues each cycle.
  - XFER: flag_org_update=1 is ignored and sets err_update.
- Transfer timing (update sampled at edge N):
  - llr_wr_en=1 on the cycles following edges N+2 .. N+FRAME_WORDS+1, one word per cycle, no gaps.
  - llr_wr_addr runs 0..FRAME_WORDS-1 in order; llr_wr_data is the matching bank word.
  - llr_wr_en is 0 at all other times; llr_wr_addr and llr_wr_data hold their last values.
  - flag_org_write_end=1 for exactly one cycle, the cycle immediately after the last llr_wr_en cycle.
  - On that same edge: the count decrements, rd_bank toggles, and state returns to IDLE.
  - Total latency: update to write_end = FRAME_WORDS+2 cycles.
- Count:
  - The frame being transferred stays counted, and its bank stays protected, until write_end.
  - Increment and decrement on the same edge leave the count unchanged.
  - Count never exceeds 2; in_ready=0 guarantees this.
- Bank safety: the bank being filled is never the bank being read. When count=2, wr_bank equals rd_bank, and in_ready=0 blocks writes.
- Arithmetic: counters wrap exactly at FRAME_WORDS-1; there are no carries into the bank bits.
- err_update clears only on reset.

Test Plan:
- Reset, then 8 cycles idle -> in_ready=1, flag_buffer_in=0, llr_wr_en=0, flag_org_write_end=0, err_update=0.
- FRAME_WORDS=4: stream 0xA0..0xA3 with continuous valid -> flag_buffer_in=1 after the 4th beat. Pulse update -> llr_wr_en high 4 consecutive cycles with addr 0,1,2,3 and data A0..A3. write_end one cycle after the last write, 6 cycles after the update edge. flag_buffer_in=0.
- Stream 3 frames back-to-back -> after 8 beats flag_buffer_in=2 and in_ready=0, so the 3rd frame stalls. Pulse update -> the first frame is written. At write_end flag_buffer_in=1 and in_ready=1 the next cycle; frame 3 fills bank 0. A second update outputs frame 2 data.
- Complete the last input beat of a new frame on the same edge as write_end -> flag_buffer_in unchanged (1 stays 1).
- Update with flag_buffer_in=0, then a second update mid-XFER -> no writes from the spurious pulses, err_update=1 sticky, and the in-progress transfer completes normally.
- Assert sys_rst on the 2nd write cycle of a transfer -> llr_wr_en=0 and all outputs 0 the next cycle, no write_end. A fresh frame plus update afterwards transfers correctly from addr 0.

Source files
------------

// File: rtl/llr_frame_buffer.sv
// Ping-pong input frame buffer feeding ram_llr for the LDPC decoder.
// Update to write_end is FRAME_WORDS+2 cycles; in_ready drops while both banks hold complete frames.
module llr_frame_buffer #(
    parameter int DATA_W      = 64,
    parameter int FRAME_WORDS = 533,
    parameter int ADDR_W      = 10
) (
    input  logic              sys_clk,
    input  logic              sys_rst,
    input  logic              in_valid,
    input  logic [DATA_W-1:0] in_data,
    output logic              in_ready,
    input  logic              flag_org_update,
    output logic [1:0]        flag_buffer_in,
    output logic              flag_org_write_end,
    output logic              llr_wr_en,
    output logic [ADDR_W-1:0] llr_wr_addr,
    output logic [DATA_W-1:0] llr_wr_data,
    output logic              err_update
);

    localparam int IDX_W = (FRAME_WORDS > 1) ? $clog2(FRAME_WORDS) : 1;
    localparam logic [IDX_W-1:0]  LAST_IDX  = IDX_W'(FRAME_WORDS - 1);
    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(FRAME_WORDS - 1);

    typedef enum logic {IDLE, XFER} state_t;

    state_t state, state_nxt;

    logic [DATA_W-1:0] mem [2][FRAME_WORDS];

    logic              wr_bank;
    logic              rd_bank;
    logic [IDX_W-1:0]  wr_cnt;
    logic [IDX_W-1:0]  rd_cnt;
    logic              rd_act;
    logic              s1_vld;
    logic [IDX_W-1:0]  s1_idx;
    logic [DATA_W-1:0] s1_dat;
    logic [1:0]        count;
    logic [1:0]        count_nxt;
    logic              accept;
    logic              frame_in;
    logic              xfer_done;
    logic              start;
    logic              err_set;

    assign accept         = in_valid & in_ready;
    assign frame_in       = accept && (wr_cnt == LAST_IDX);
    assign xfer_done      = (state == XFER) && llr_wr_en && (llr_wr_addr == LAST_ADDR);
    assign flag_buffer_in = count;

    always_comb begin
        state_nxt = state;
        start     = 1'b0;
        err_set   = 1'b0;
        case (state)
            IDLE: begin
                if (flag_org_update) begin
                    if (count != 2'd0) begin
                        start     = 1'b1;
                        state_nxt = XFER;
                    end else begin
                        err_set = 1'b1;
                    end
                end
            end
            XFER: begin
                if (flag_org_update) begin
                    err_set = 1'b1;
                end
                if (xfer_done) begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        count_nxt = count;
        case ({frame_in, xfer_done})
            2'b10:   count_nxt = count + 2'd1;
            2'b01:   count_nxt = count - 2'd1;
            default: count_nxt = count;
        endcase
    end

    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            state              <= IDLE;
            count              <= 2'd0;
            in_ready           <= 1'b0;
            wr_bank            <= 1'b0;
            wr_cnt             <= '0;
            rd_bank            <= 1'b0;
            rd_cnt             <= '0;
            rd_act             <= 1'b0;
            s1_vld             <= 1'b0;
            s1_idx             <= '0;
            flag_org_write_end <= 1'b0;
            llr_wr_en          <= 1'b0;
            llr_wr_addr        <= '0;
            llr_wr_data        <= '0;
            err_update         <= 1'b0;
        end else begin
            state      <= state_nxt;
            count      <= count_nxt;
            in_ready   <= (count_nxt < 2'd2);
            err_update <= err_update | err_set;

            if (accept) begin
                if (wr_cnt == LAST_IDX) begin
                    wr_cnt  <= '0;
                    wr_bank <= ~wr_bank;
                end else begin
                    wr_cnt <= wr_cnt + 1'b1;
                end
            end

            // Read issue: one word per cycle for a whole frame, starting the cycle after the update.
            if (start) begin
                rd_act <= 1'b1;
                rd_cnt <= '0;
            end else if (rd_act) begin
                if (rd_cnt == LAST_IDX) begin
                    rd_act <= 1'b0;
                    rd_cnt <= '0;
                end else begin
                    rd_cnt <= rd_cnt + 1'b1;
                end
            end

            s1_vld <= rd_act;
            s1_idx <= rd_cnt;

            llr_wr_en <= s1_vld;
            if (s1_vld) begin
                llr_wr_addr <= ADDR_W'(s1_idx);
                llr_wr_data <= s1_dat;
            end

            flag_org_write_end <= xfer_done;
            if (xfer_done) begin
                rd_bank <= ~rd_bank;
            end
        end
    end

    // Bank storage carries no reset; contents after reset are don't-care.
    always_ff @(posedge sys_clk) begin
        if (accept) begin
            mem[wr_bank][wr_cnt] <= in_data;
        end
        s1_dat <= mem[rd_bank][rd_cnt];
    end

endmodule
